relu_activation_unit: RTL and testbench

- Parametrised, sequential successor to the combinational ReLU stage between layer 1 and layer 2.
- Takes a packed vector of NODES signed layer-1 sums on `trigger` and processes LANES nodes per clock over NODES/LANES beats.
- Applies ReLU or leaky-ReLU (per-run mode), then a fixed-point rescale and saturation to OUT_WIDTH.
- Presents the full layer-2 input vector with a one-cycle `done` pulse and a saturation count.

---
 rtl/relu_activation_unit.sv | 157 +++++++++++++++
 tb/tb_relu_activation_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/relu_activation_unit.sv
// Sequential ReLU / leaky-ReLU stage between layer 1 and layer 2: processes LANES
// nodes per clock, rescales and saturates each to OUT_WIDTH, and counts the clamps.
module relu_activation_unit #(
  parameter int NODES      = 4,
  parameter int LANES      = 2,
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int FRAC_SHIFT = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int SAT_W      = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           trigger,
  input  logic                           leakyMode,
  input  logic [NODES*IN_WIDTH-1:0]      sumIn,
  output logic [NODES*OUT_WIDTH-1:0]     layerOut,
  output logic                           busy,
  output logic                           done,
  output logic [SAT_W-1:0]               satCount
);

  localparam int BEATS = NODES / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic signed [IN_WIDTH-1:0] OUT_MAX = IN_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH-1:0] OUT_MIN = IN_WIDTH'(-(1 << (OUT_WIDTH - 1)));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       state_r, state_next_s;
  logic [BW-1:0]                beat_r;
  logic [NODES*IN_WIDTH-1:0]    shadow_r;
  logic                         leaky_r;
  logic [NODES*OUT_WIDTH-1:0]   work_r, work_next_s;
  logic [SAT_W-1:0]             acc_r, acc_next_s;
  logic [NODES*OUT_WIDTH-1:0]   layer_r;
  logic                         done_r;
  logic [SAT_W-1:0]             sat_r;
  logic [OUT_WIDTH:0]           lane_res_s [LANES];

  // Returns {saturated, result} for one node: activation, rescale, clamp.
  function automatic logic [OUT_WIDTH:0] act_node(input logic signed [IN_WIDTH-1:0] x,
                                                  input logic leaky);
    logic signed [IN_WIDTH-1:0] y;
    logic signed [IN_WIDTH-1:0] z;
    logic [OUT_WIDTH:0]         res;
    if (!x[IN_WIDTH-1]) begin
      y = x;
    end else if (leaky) begin
      y = x >>> LEAK_SHIFT;
    end else begin
      y = '0;
    end
    z = y >>> FRAC_SHIFT;
    if (z > OUT_MAX) begin
      res = {1'b1, OUT_MAX[OUT_WIDTH-1:0]};
    end else if (z < OUT_MIN) begin
      res = {1'b1, OUT_MIN[OUT_WIDTH-1:0]};
    end else begin
      res = {1'b0, z[OUT_WIDTH-1:0]};
    end
    return res;
  endfunction

  // Lane datapath: the current beat's nodes written into the next working vector.
  always_comb begin
    work_next_s = work_r;
    acc_next_s  = acc_r;
    for (int l = 0; l < LANES; l++) begin
      lane_res_s[l] = act_node(shadow_r[(int'(beat_r) * LANES + l) * IN_WIDTH +: IN_WIDTH],
                               leaky_r);
      work_next_s[(int'(beat_r) * LANES + l) * OUT_WIDTH +: OUT_WIDTH] =
        lane_res_s[l][OUT_WIDTH-1:0];
      acc_next_s = acc_next_s + SAT_W'(lane_res_s[l][OUT_WIDTH]);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (trigger) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (beat_r == BW'(BEATS - 1)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Capture, per-beat accumulation and publication of results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_r   <= '0;
      shadow_r <= '0;
      leaky_r  <= 1'b0;
      work_r   <= '0;
      acc_r    <= '0;
      layer_r  <= '0;
      done_r   <= 1'b0;
      sat_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (trigger) begin
            shadow_r <= sumIn;
            leaky_r  <= leakyMode;
            beat_r   <= '0;
            acc_r    <= '0;
          end
        end
        RUN: begin
          done_r <= 1'b0;
          work_r <= work_next_s;
          acc_r  <= acc_next_s;
          beat_r <= beat_r + BW'(1);
        end
        DONE: begin
          layer_r <= work_r;
          sat_r   <= acc_r;
          done_r  <= 1'b1;
        end
        default: done_r <= 1'b0;
      endcase
    end
  end

  assign layerOut = layer_r;
  assign done     = done_r;
  assign satCount = sat_r;
  assign busy     = (state_r != IDLE);

endmodule

// File: tb/tb_relu_activation_unit.sv
// Self-checking bench for relu_activation_unit: directed cases from the plan plus
// randomized runs checked against an arithmetic reference model.
module tb_relu_activation_unit;

  localparam int NODES = 4;
  localparam int IW    = 16;
  localparam int OW    = 8;
  localparam int SW    = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  trigger;
  logic                  leakyMode;
  logic [NODES*IW-1:0]   sumIn;
  logic [NODES*OW-1:0]   layerOut;
  logic                  busy;
  logic                  done;
  logic [SW-1:0]         satCount;

  int total = 0;
  int bad   = 0;

  relu_activation_unit dut (
    .clk(clk), .reset(reset), .trigger(trigger), .leakyMode(leakyMode),
    .sumIn(sumIn), .layerOut(layerOut), .busy(busy), .done(done), .satCount(satCount)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int fdiv(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Reference: floor-division rescale and clamp to the signed 8-bit range.
  task automatic model(input logic [NODES*IW-1:0] vec, input logic lk,
                       output logic [NODES*OW-1:0] o, output logic [SW-1:0] s);
    int x, y, z, n;
    n = 0;
    o = '0;
    for (int i = 0; i < NODES; i++) begin
      x = int'($signed(vec[i*IW +: IW]));
      if (x >= 0) y = x;
      else if (lk) y = fdiv(x, 8);
      else y = 0;
      z = fdiv(y, 16);
      if (z > 127) begin z = 127; n++; end
      else if (z < -128) begin z = -128; n++; end
      o[i*OW +: OW] = OW'(z);
    end
    s = SW'(n);
  endtask

  task automatic do_run(input logic [NODES*IW-1:0] vec, input logic lk,
                        input logic [NODES*OW-1:0] eo, input logic [SW-1:0] es,
                        input string tag);
    int lat, busy_n;
    sumIn = vec; leakyMode = lk; trigger = 1'b1;
    step();
    trigger = 1'b0; sumIn = ~vec; leakyMode = ~lk;
    lat = 0; busy_n = 0;
    if (busy) busy_n++;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (done) begin lat = k; break; end
      if (busy) busy_n++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd3);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd3);
    chk({tag, "_layerOut"}, 64'(layerOut), 64'(eo));
    chk({tag, "_satCount"}, 64'(satCount), 64'(es));
    step();
    chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [NODES*IW-1:0] va, vb;
    logic [NODES*OW-1:0] eo;
    logic [SW-1:0]       es;
    logic                lk;
    int pulses, e1, e2, edge_n;

    // Reset with trigger asserted.
    reset = 1'b1; trigger = 1'b1; leakyMode = 1'b0; sumIn = 64'h1234_5678_9ABC_DEF0;
    repeat (3) step();
    chk("rst_layerOut", 64'(layerOut), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_satCount", 64'(satCount), 64'd0);
    reset = 1'b0; trigger = 1'b0;
    repeat (3) step();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);

    // Directed cases.
    do_run(64'h0010_0000_FF38_0135, 1'b0, 32'h01_00_00_13, 3'd0, "relu");
    do_run(64'h0010_0000_FF38_0135, 1'b1, 32'h01_00_FE_13, 3'd0, "leaky");
    do_run(64'hFFFF_07F0_8000_7FFF, 1'b1, 32'hFF_7F_80_7F, 3'd2, "sat_leaky");
    do_run(64'hFFFF_07F0_8000_7FFF, 1'b0, 32'h00_7F_00_7F, 3'd1, "sat_relu");

    // Input isolation: new data and trigger during RUN are ignored.
    va = 64'h0200_FE00_0123_0FFF;
    model(va, 1'b0, eo, es);
    sumIn = va; leakyMode = 1'b0; trigger = 1'b1;
    step();
    sumIn = 64'h7FFF_7FFF_7FFF_7FFF; leakyMode = 1'b1;
    step();
    step();
    trigger = 1'b0;
    pulses = 0; e1 = 0;
    for (int k = 3; k <= 10; k++) begin
      step();
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          e1 = k;
          chk("iso_layerOut", 64'(layerOut), 64'(eo));
          chk("iso_satCount", 64'(satCount), 64'(es));
        end
      end
    end
    chk("iso_latency", 64'(e1), 64'd3);
    chk("iso_pulses", 64'(pulses), 64'd1);
    chk("iso_idle", 64'(busy), 64'd0);

    // Abort: reset on the second RUN cycle.
    sumIn = 64'h0100_0100_0100_0100; leakyMode = 1'b0; trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("abort_layerOut", 64'(layerOut), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_satCount", 64'(satCount), 64'd0);
    step();
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);

    // Back-to-back with trigger held high.
    va = 64'hF000_0555_8123_0400;
    vb = 64'h0033_FF00_7000_FE80;
    sumIn = va; leakyMode = 1'b1; trigger = 1'b1;
    step();
    sumIn = vb; leakyMode = 1'b0;
    pulses = 0; e1 = 0; e2 = 0; edge_n = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          e1 = k;
          model(va, 1'b1, eo, es);
          chk("b2b_run1_layerOut", 64'(layerOut), 64'(eo));
          chk("b2b_run1_satCount", 64'(satCount), 64'(es));
        end else begin
          e2 = k;
          model(vb, 1'b0, eo, es);
          chk("b2b_run2_layerOut", 64'(layerOut), 64'(eo));
          chk("b2b_run2_satCount", 64'(satCount), 64'(es));
          break;
        end
      end
    end
    chk("b2b_pulses", 64'(pulses), 64'd2);
    chk("b2b_first_latency", 64'(e1), 64'd3);
    chk("b2b_low_gap", 64'(e2 - e1 - 1), 64'd3);
    trigger = 1'b0;
    repeat (6) step();

    // Randomized runs against the reference model.
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < NODES; i++) begin
        if ($urandom_range(1, 0) == 1) va[i*IW +: IW] = IW'($urandom);
        else va[i*IW +: IW] = IW'($urandom_range(4095, 0)) - IW'(2048);
      end
      lk = 1'($urandom_range(1, 0));
      model(va, lk, eo, es);
      do_run(va, lk, eo, es, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
